// File: rtl/fifo_rd_stream.sv
// Read-side controller for the dual-port RAM FIFO: owns the read pointer, issues
// RAM reads and streams the words out through a 2-entry skid buffer.
module fifo_rd_stream #(
  parameter int Depth    = 8,
  parameter int Width    = 4,
  parameter int PtrWidth = $clog2(Depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PtrWidth:0]   i_wr_ptr_bin,
  output logic                o_rd_en,
  output logic [PtrWidth-1:0] o_rd_ptr,
  output logic                o_empty,
  input  logic [Width-1:0]    i_rd_data,
  output logic [PtrWidth:0]   o_rd_ptr_bin,
  output logic [PtrWidth:0]   o_count,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [Width-1:0]    o_data,
  output logic                o_err
);

  logic [PtrWidth:0] rd_ptr;
  logic [PtrWidth:0] count;
  logic              inflight;
  logic              push;
  logic              pop;
  logic [1:0]        occ;
  logic [Width-1:0]  buf_mem [2];
  logic              buf_head;
  logic              buf_tail;
  logic [1:0]        buf_count;
  logic              err;

  always_comb begin
    count   = i_wr_ptr_bin - rd_ptr;
    o_count = count;
    o_empty = (count == '0);
    pop     = o_valid && i_ready;
    push    = inflight;
    occ     = buf_count + {1'b0, inflight};
    // Credit check: a slot must be free once this cycle's pop retires.
    o_rd_en = !rst && !o_empty && ({1'b0, occ} < (3'd2 + {2'b00, pop}));
  end

  assign o_rd_ptr     = rd_ptr[PtrWidth-1:0];
  assign o_rd_ptr_bin = rd_ptr;
  assign o_valid      = (buf_count != 2'd0);
  assign o_data       = buf_mem[buf_head];
  assign o_err        = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      inflight <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (o_rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      inflight <= o_rd_en;
      if (count > (PtrWidth + 1)'(Depth)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_head   <= 1'b0;
      buf_tail   <= 1'b0;
      buf_count  <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[buf_tail] <= i_rd_data;
        buf_tail          <= ~buf_tail;
      end
      if (pop) begin
        buf_head <= ~buf_head;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && buf_count == 2'd2));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-output RAM model.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] i_wr_ptr_bin = '0;
  logic       o_rd_en;
  logic [2:0] o_rd_ptr;
  logic       o_empty;
  logic [3:0] i_rd_data = '0;
  logic [3:0] o_rd_ptr_bin;
  logic [3:0] o_count;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [3:0] o_data;
  logic       o_err;

  logic [3:0] ram [8];
  logic [2:0] rd_log [$];
  logic [3:0] got [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fifo_rd_stream #(.Depth(8), .Width(4)) dut (
    .clk(clk), .rst(rst), .i_wr_ptr_bin(i_wr_ptr_bin), .o_rd_en(o_rd_en),
    .o_rd_ptr(o_rd_ptr), .o_empty(o_empty), .i_rd_data(i_rd_data),
    .o_rd_ptr_bin(o_rd_ptr_bin), .o_count(o_count), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rd_en) begin
      i_rd_data <= ram[o_rd_ptr];
      rd_log.push_back(o_rd_ptr);
    end
  end

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) got.push_back(o_data);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 4'(i);

    // 1: asynchronous reset and idle state
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ptr_bin", 32'(o_rd_ptr_bin), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_empty", 32'(o_empty), 32'd1);
    check("idle_count", 32'(o_count), 32'd0);
    check("idle_rd_en", 32'(o_rd_en), 32'd0);

    // 2: single word latency
    ram[0] = 4'hA;
    i_ready = 1'b1;
    step();
    i_wr_ptr_bin = 4'd1;
    @(negedge clk);
    check("t2_rd_en", 32'(o_rd_en), 32'd1);
    check("t2_rd_ptr", 32'(o_rd_ptr), 32'd0);
    check("t2_valid_e0", 32'(o_valid), 32'd0);
    step();
    @(negedge clk);
    check("t2_rd_en_off", 32'(o_rd_en), 32'd0);
    check("t2_valid_e1", 32'(o_valid), 32'd0);
    check("t2_ptr_bin", 32'(o_rd_ptr_bin), 32'd1);
    check("t2_empty", 32'(o_empty), 32'd1);
    step();
    @(negedge clk);
    check("t2_valid_e2", 32'(o_valid), 32'd1);
    check("t2_data", 32'(o_data), 32'hA);
    step();
    @(negedge clk);
    check("t2_valid_drop", 32'(o_valid), 32'd0);

    // 3: full RAM burst, one word per cycle
    for (int i = 0; i < 8; i++) ram[i] = 4'(i);
    i_wr_ptr_bin = 4'd0;
    do_reset();
    got.delete();
    i_wr_ptr_bin = 4'd8;
    #1 check("t3_count_full", 32'(o_count), 32'd8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("t3_valid_%0d", i), 32'(o_valid), 32'((i >= 2) && (i <= 9)));
      if (i >= 2 && i <= 9) check($sformatf("t3_data_%0d", i), 32'(o_data), 32'(i - 2));
      if (i == 8) check("t3_count_drained", 32'(o_count), 32'd0);
    end
    check("t3_words", got.size(), 32'd8);

    // 4: backpressure then drain
    for (int i = 0; i < 5; i++) ram[i] = 4'(i + 5);
    i_ready = 1'b0;
    i_wr_ptr_bin = 4'd0;
    do_reset();
    rd_log.delete();
    got.delete();
    i_wr_ptr_bin = 4'd5;
    repeat (3) @(negedge clk);
    check("t4_data_early", 32'(o_data), 32'd5);
    repeat (3) @(negedge clk);
    check("t4_reads", rd_log.size(), 32'd2);
    check("t4_ptr_bin", 32'(o_rd_ptr_bin), 32'd2);
    check("t4_count", 32'(o_count), 32'd3);
    check("t4_valid", 32'(o_valid), 32'd1);
    check("t4_data_held", 32'(o_data), 32'd5);
    step();
    i_ready = 1'b1;
    repeat (15) @(negedge clk);
    check("t4_words", got.size(), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("t4_word_%0d", i), 32'(got[i]), 32'(i + 5));

    // 5: two batches with pointer wrap
    for (int i = 0; i < 8; i++) ram[i] = 4'(i);
    i_wr_ptr_bin = 4'd0;
    do_reset();
    rd_log.delete();
    got.delete();
    i_wr_ptr_bin = 4'd8;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 4; i++) ram[i] = 4'(i + 8);
    step();
    i_wr_ptr_bin = 4'd12;
    repeat (8) @(negedge clk);
    check("t5_reads", rd_log.size(), 32'd12);
    for (int i = 0; i < 12 && i < rd_log.size(); i++)
      check($sformatf("t5_addr_%0d", i), 32'(rd_log[i]), 32'(i % 8));
    check("t5_words", got.size(), 32'd12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      check($sformatf("t5_word_%0d", i), 32'(got[i]), 32'(i));
    check("t5_ptr_bin", 32'(o_rd_ptr_bin), 32'b1100);
    check("t5_empty", 32'(o_empty), 32'd1);

    // 6: overrun error is sticky until reset, reset drops buffered words
    i_ready = 1'b0;
    i_wr_ptr_bin = 4'd0;
    do_reset();
    i_wr_ptr_bin = 4'd9;
    @(negedge clk);
    check("t6_count", 32'(o_count), 32'd9);
    check("t6_err_pre", 32'(o_err), 32'd0);
    step();
    @(negedge clk);
    check("t6_err_set", 32'(o_err), 32'd1);
    repeat (4) @(negedge clk);
    check("t6_err_sticky", 32'(o_err), 32'd1);
    check("t6_valid", 32'(o_valid), 32'd1);
    check("t6_ptr_bin", 32'(o_rd_ptr_bin), 32'd2);
    #2 rst = 1'b1;
    i_wr_ptr_bin = 4'd0;
    #1;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_err", 32'(o_err), 32'd0);
    check("t6_rst_ptr", 32'(o_rd_ptr_bin), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_log.delete();
    i_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_post_valid", 32'(o_valid), 32'd0);
    check("t6_post_reads", rd_log.size(), 32'd0);
    check("t6_post_err", 32'(o_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
